sensor_conditioner: RTL and testbench



---
 rtl/traffic_pkg.sv | 32 +++
 rtl/sensor_conditioner_if.sv | 27 ++
 rtl/sensor_channel.sv | 150 +++++++++++++++
 rtl/sensor_conditioner.sv | 48 ++++
 tb/tb_sensor_conditioner.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller and its sensor front end.
// Holds the per-channel sensor FSM state encoding, the default timing constants
// and the light encodings that the downstream controller also uses.
package traffic_pkg;

    // Default sensor conditioning timing, in clock cycles.
    localparam int unsigned DefSyncStages     = 2;
    localparam int unsigned DefDebounceCycles = 4;
    localparam int unsigned DefHoldCycles     = 8;
    localparam int unsigned DefStuckCycles    = 1000;

    typedef enum logic [2:0] {
        StIdle,
        StQual,
        StPresent,
        StHold,
        StFault
    } sensor_state_e;

    typedef enum logic [1:0] {
        LightRed    = 2'b00,
        LightYellow = 2'b01,
        LightGreen  = 2'b10
    } light_e;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sensor_conditioner_if.sv
// Signal bundle between the raw loop detectors and the traffic controller.
//   ns_raw, ew_raw         : raw asynchronous loop detector levels
//   NS_sensor, EW_sensor   : conditioned presence levels
//   ns_arrive, ew_arrive   : one-cycle pulse per accepted arrival
//   ns_fault, ew_fault     : stuck-sensor flags
// master: the side that drives the raw inputs and consumes the conditioned outputs.
// slave : the conditioner itself.
interface sensor_conditioner_if;
    logic ns_raw;
    logic ew_raw;
    logic NS_sensor;
    logic EW_sensor;
    logic ns_arrive;
    logic ew_arrive;
    logic ns_fault;
    logic ew_fault;

    modport master (
        output ns_raw, ew_raw,
        input  NS_sensor, EW_sensor, ns_arrive, ew_arrive, ns_fault, ew_fault
    );

    modport slave (
        input  ns_raw, ew_raw,
        output NS_sensor, EW_sensor, ns_arrive, ew_arrive, ns_fault, ew_fault
    );
endinterface

// File: rtl/sensor_channel.sv
// One vehicle-loop conditioning channel: synchroniser, debounce/hold/stuck FSM
// and a single shared, saturating counter.
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   raw    : asynchronous raw loop level
//   sensor : registered conditioned presence
//   arrive : registered one-cycle pulse on each newly accepted arrival
//   fault  : registered stuck-sensor flag
module sensor_channel
    import traffic_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DefSyncStages,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned HOLD_CYCLES     = DefHoldCycles,
    parameter int unsigned STUCK_CYCLES    = DefStuckCycles
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic sensor,
    output logic arrive,
    output logic fault
);

    localparam int unsigned CntW =
        $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, STUCK_CYCLES)) + 1;

    typedef logic [CntW-1:0] cnt_t;

    localparam cnt_t CntSat    = '1;
    localparam cnt_t DebLast   = cnt_t'(DEBOUNCE_CYCLES - 1);
    localparam cnt_t HoldLast  = cnt_t'(HOLD_CYCLES - 1);
    localparam cnt_t StuckLast = cnt_t'(STUCK_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    sensor_state_e          state_q, state_d;
    cnt_t                   cnt_q, cnt_d, cnt_inc;
    logic                   sensor_q, sensor_d;
    logic                   arrive_q, arrive_d;
    logic                   fault_q, fault_d;

    assign s       = sync_q[SYNC_STAGES-1];
    assign cnt_inc = (cnt_q == CntSat) ? cnt_q : cnt_q + cnt_t'(1);

    // State register, counter, synchroniser and output flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            state_q  <= StIdle;
            cnt_q    <= '0;
            sensor_q <= 1'b0;
            arrive_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sensor_q <= sensor_d;
            arrive_q <= arrive_d;
            fault_q  <= fault_d;
        end
    end

    // Next state. Entering QUAL or HOLD counts the triggering sample as the
    // first one, so the qualification windows are exactly N samples long.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d = StPresent;
                        cnt_d   = '0;
                    end else begin
                        state_d = StQual;
                        cnt_d   = cnt_t'(1);
                    end
                end
            end
            StQual: begin
                if (!s) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == DebLast) begin
                    state_d = StPresent;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StPresent: begin
                if (!s) begin
                    if (HOLD_CYCLES == 1) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else begin
                        state_d = StHold;
                        cnt_d   = cnt_t'(1);
                    end
                end else if (cnt_q == StuckLast) begin
                    state_d = StFault;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StHold: begin
                if (s) begin
                    state_d = StPresent;
                    cnt_d   = '0;
                end else if (cnt_q == HoldLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StFault: begin
                // Needs DEBOUNCE_CYCLES clean low samples in a row to clear.
                if (s) begin
                    cnt_d = '0;
                end else if (cnt_q == DebLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs decoded from the next state so that they register on the same
    // edge as the state change. A return from HOLD is not a new arrival.
    always_comb begin
        sensor_d = state_d inside {StPresent, StHold, StFault};
        fault_d  = (state_d == StFault);
        arrive_d = (state_d == StPresent) && (state_q inside {StIdle, StQual});
    end

    assign sensor = sensor_q;
    assign arrive = arrive_q;
    assign fault  = fault_q;

endmodule

// File: rtl/sensor_conditioner.sv
// Conditions the raw NS and EW vehicle-loop inputs into clean presence levels,
// arrival pulses and stuck-sensor flags for the traffic controller. The two
// channels are identical and independent.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : raw inputs in, conditioned outputs out (slave side)
module sensor_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DefSyncStages,
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned HOLD_CYCLES     = DefHoldCycles,
    parameter int unsigned STUCK_CYCLES    = DefStuckCycles
) (
    input logic                 clk,
    input logic                 rst,
    sensor_conditioner_if.slave bus
);

    sensor_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_ns (
        .clk    (clk),
        .rst    (rst),
        .raw    (bus.ns_raw),
        .sensor (bus.NS_sensor),
        .arrive (bus.ns_arrive),
        .fault  (bus.ns_fault)
    );

    sensor_channel #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .STUCK_CYCLES    (STUCK_CYCLES)
    ) u_ew (
        .clk    (clk),
        .rst    (rst),
        .raw    (bus.ew_raw),
        .sensor (bus.EW_sensor),
        .arrive (bus.ew_arrive),
        .fault  (bus.ew_fault)
    );

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner (SYNC 2, DEBOUNCE 4, HOLD 8, STUCK 16).
// Cycle c is the interval after edge c; edge numbering restarts at 0 on the
// last reset edge of each vector. Raw levels driven in cycle c are first seen
// by the FSM at edge c+3.
module tb_sensor_conditioner;

    typedef struct {
        int on0;
        int off0;
        int on1;
        int off1;
    } wave_t;

    // Edge numbers of observed events; -1 means the event never happened.
    typedef struct {
        int rise;
        int fall;
        int arrives;
        int last_arrive;
        int fault_rise;
        int fault_fall;
    } obs_t;

    typedef struct {
        string name;
        wave_t ns_w;
        wave_t ew_w;
        obs_t  ns_e;
        obs_t  ew_e;
        int    edges;
    } vec_t;

    typedef struct {
        string name;
        int    off;
        int    n;
        int    pre_sen;
        int    pre_flt;
    } rst_vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_mis;

    sensor_conditioner_if bus ();

    sensor_conditioner #(
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (8),
        .STUCK_CYCLES    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    function automatic wave_t mk_w(int on0, int off0, int on1, int off1);
        wave_t w;
        w.on0 = on0; w.off0 = off0; w.on1 = on1; w.off1 = off1;
        return w;
    endfunction

    function automatic obs_t mk_e(int rise, int fall, int arrives, int last_arrive,
                                  int fault_rise, int fault_fall);
        obs_t o;
        o.rise = rise; o.fall = fall; o.arrives = arrives; o.last_arrive = last_arrive;
        o.fault_rise = fault_rise; o.fault_fall = fault_fall;
        return o;
    endfunction

    function automatic logic wave_at(wave_t w, int c);
        return (c >= w.on0 && c < w.off0) || (c >= w.on1 && c < w.off1);
    endfunction

    function automatic logic [5:0] outs();
        return {bus.NS_sensor, bus.ns_arrive, bus.ns_fault,
                bus.EW_sensor, bus.ew_arrive, bus.ew_fault};
    endfunction

    task automatic check_int(string name, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Two reset edges with the given raw levels; outputs must read 0 after each.
    task automatic do_reset(logic ns_lvl, logic ew_lvl, string name);
        rst        = 1'b1;
        bus.ns_raw = ns_lvl;
        bus.ew_raw = ew_lvl;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_int({name, "/rst_outs"}, int'(outs()), 0);
        end
        rst = 1'b0;
    endtask

    task automatic check_obs(string name, obs_t act, obs_t exp);
        check_int({name, "/rise"}, act.rise, exp.rise);
        check_int({name, "/fall"}, act.fall, exp.fall);
        check_int({name, "/arrives"}, act.arrives, exp.arrives);
        check_int({name, "/last_arrive"}, act.last_arrive, exp.last_arrive);
        check_int({name, "/fault_rise"}, act.fault_rise, exp.fault_rise);
        check_int({name, "/fault_fall"}, act.fault_fall, exp.fault_fall);
    endtask

    task automatic run_vector(vec_t v);
        obs_t o[2];
        logic sp[2];
        logic fp[2];
        logic sen[2];
        logic arr[2];
        logic flt[2];
        for (int c = 0; c < 2; c++) begin
            o[c] = mk_e(-1, -1, 0, -1, -1, -1);
            sp[c] = 1'b0;
            fp[c] = 1'b0;
        end
        do_reset(wave_at(v.ns_w, 0), wave_at(v.ew_w, 0), v.name);
        for (int k = 0; k < v.edges; k++) begin
            bus.ns_raw = wave_at(v.ns_w, k);
            bus.ew_raw = wave_at(v.ew_w, k);
            @(posedge clk);
            #1;
            sen[0] = bus.NS_sensor; arr[0] = bus.ns_arrive; flt[0] = bus.ns_fault;
            sen[1] = bus.EW_sensor; arr[1] = bus.ew_arrive; flt[1] = bus.ew_fault;
            for (int c = 0; c < 2; c++) begin
                if (sen[c] && !sp[c] && o[c].rise < 0) o[c].rise = k + 1;
                if (!sen[c] && sp[c] && o[c].fall < 0) o[c].fall = k + 1;
                if (arr[c]) begin
                    o[c].arrives++;
                    o[c].last_arrive = k + 1;
                end
                if (flt[c] && !fp[c] && o[c].fault_rise < 0) o[c].fault_rise = k + 1;
                if (!flt[c] && fp[c] && o[c].fault_fall < 0) o[c].fault_fall = k + 1;
                sp[c] = sen[c];
                fp[c] = flt[c];
            end
        end
        check_obs({v.name, "/ns"}, o[0], v.ns_e);
        check_obs({v.name, "/ew"}, o[1], v.ew_e);
    endtask

    // Drive both channels into a given state, reset there, then re-qualify a
    // level that is already high.
    task automatic run_rst_state(rst_vec_t r);
        int rise_ns;
        int rise_ew;
        do_reset(1'b1, 1'b1, r.name);
        for (int k = 0; k < r.n; k++) begin
            bus.ns_raw = (k < r.off);
            bus.ew_raw = (k < r.off);
            @(posedge clk);
            #1;
        end
        check_int({r.name, "/pre_ns_sensor"}, int'(bus.NS_sensor), r.pre_sen);
        check_int({r.name, "/pre_ew_fault"}, int'(bus.ew_fault), r.pre_flt);
        rst        = 1'b1;
        bus.ns_raw = 1'b1;
        bus.ew_raw = 1'b1;
        @(posedge clk);
        #1;
        check_int({r.name, "/mid_rst_outs"}, int'(outs()), 0);
        rst     = 1'b0;
        rise_ns = -1;
        rise_ew = -1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (bus.NS_sensor && rise_ns < 0) rise_ns = k + 1;
            if (bus.EW_sensor && rise_ew < 0) rise_ew = k + 1;
        end
        check_int({r.name, "/requal_ns"}, rise_ns, 6);
        check_int({r.name, "/requal_ew"}, rise_ew, 6);
    endtask

    vec_t     vecs[11];
    rst_vec_t rvecs[4];

    initial begin
        wave_t none;
        obs_t  idle;
        n_cmp      = 0;
        n_mis      = 0;
        rst        = 1'b1;
        bus.ns_raw = 1'b0;
        bus.ew_raw = 1'b0;

        none = mk_w(-1, -1, -1, -1);
        idle = mk_e(-1, -1, 0, -1, -1, -1);

        vecs[0]  = '{"both_hi_from_reset", mk_w(0, 12, -1, -1), mk_w(0, 12, -1, -1),
                     mk_e(6, 22, 1, 6, -1, -1), mk_e(6, 22, 1, 6, -1, -1), 30};
        vecs[1]  = '{"ns_pulse3", mk_w(0, 3, -1, -1), none, idle, idle, 20};
        vecs[2]  = '{"ns_pulse4", mk_w(0, 4, -1, -1), none,
                     mk_e(6, 14, 1, 6, -1, -1), idle, 25};
        vecs[3]  = '{"ew_pulse4", none, mk_w(0, 4, -1, -1),
                     idle, mk_e(6, 14, 1, 6, -1, -1), 25};
        vecs[4]  = '{"ns_gap5", mk_w(0, 10, 15, 25), none,
                     mk_e(6, 35, 1, 6, -1, -1), idle, 45};
        vecs[5]  = '{"ns_gap7", mk_w(0, 10, 17, 27), none,
                     mk_e(6, 37, 1, 6, -1, -1), idle, 45};
        vecs[6]  = '{"ns_gap8", mk_w(0, 10, 18, 28), none,
                     mk_e(6, 20, 2, 24, -1, -1), idle, 45};
        vecs[7]  = '{"ew_stuck", none, mk_w(0, 30, -1, -1),
                     idle, mk_e(6, 36, 1, 6, 22, 36), 45};
        vecs[8]  = '{"ew_stuck_short_gap", none, mk_w(0, 30, 33, 50),
                     idle, mk_e(6, 56, 1, 6, 22, 56), 65};
        vecs[9]  = '{"simul_pulse4_stuck", mk_w(0, 4, -1, -1), mk_w(0, 30, -1, -1),
                     mk_e(6, 14, 1, 6, -1, -1), mk_e(6, 36, 1, 6, 22, 36), 45};
        vecs[10] = '{"opposite_phase", mk_w(0, 10, 18, 28), mk_w(10, 18, 28, 40),
                     mk_e(6, 20, 2, 24, -1, -1), mk_e(16, 28, 2, 34, -1, -1), 55};

        rvecs[0] = '{"rst_in_qual", 100, 4, 0, 0};
        rvecs[1] = '{"rst_in_present", 100, 8, 1, 0};
        rvecs[2] = '{"rst_in_hold", 8, 13, 1, 0};
        rvecs[3] = '{"rst_in_fault", 100, 25, 1, 1};

        for (int i = 0; i < 11; i++) run_vector(vecs[i]);
        for (int i = 0; i < 4; i++) run_rst_state(rvecs[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
